nlc_horner_seq: RTL and testbench
=================================

// Module: nlc_horner_seq
// PURPOSE
//  Parametrised multi-channel nonlinearity corrector: time-multiplexes one fixed-point multiply-add datapath over N_CH channels.
//  Per channel: normalise x_adc with neg_mean/recip_stdev, evaluate an ORDER-th polynomial by Horner, saturate to x_lin.
//  Generalises the 16-ch/5th-order float NLC: any channel count, any polynomial order, busy/abort semantics, optional error output.
// PARAMETERS
//  N_CH   16  channels evaluated per srdyi batch (>=1)
//  ORDER  5   polynomial order; ORDER+1 coefficients per channel (>=1)
//  XW     21  ADC / x_lin / x_ref width, signed two's complement
//  W      48  internal and coefficient width, signed
//  FRAC   16  fractional bits of all W-wide values (Q(W-FRAC).FRAC)
// PORTS
//  clk          in   1                clock
//  reset        in   1                synchronous, active-high
//  srdyi        in   1                batch valid; all channel inputs sampled this cycle
//  srdyo        out  1                one-cycle pulse: x_lin updated for whole batch
//  busy         out  1                batch in progress; srdyi ignored while high
//  x_adc        in   N_CH*XW          ch c at [c*XW +: XW]
//  neg_mean     in   N_CH*W           ch c at [c*W +: W]
//  recip_stdev  in   N_CH*W           ch c at [c*W +: W]
//  coeff        in   N_CH*(ORDER+1)*W ch c coeff k at [(c*(ORDER+1)+k)*W +: W]
//  x_lin        out  N_CH*XW          corrected outputs, registered
//  x_ref        in   N_CH*XW          NLC_ERR_EN only
//  err          out  N_CH*(XW+1)      NLC_ERR_EN only: |x_lin - x_ref|, unsigned
// BEHAVIOUR
//  Reset: state IDLE, srdyo=0, busy=0, x_lin=0, err=0, channel/step counters=0. Applies at any cycle; aborts a batch, no srdyo.
//  States IDLE -> NORM -> HORN -> WRITE -> (NORM next ch | DONE) -> IDLE.
//  IDLE: srdyi=1 registers all inputs (shadow copy), ch=0, -> NORM, busy=1 next cycle. Input changes afterwards have no effect.
//  NORM (1 cyc): t = (sext(x_adc)<<FRAC) + neg_mean; xn = sat_W((t*recip_stdev)>>>FRAC); acc = coeff[ORDER].
//  HORN (ORDER cyc, k=ORDER-1..0): acc = sat_W(((acc*xn)>>>FRAC) + coeff[k]); products full 2W, arithmetic shift (floor).
//  WRITE (1 cyc): staged x_lin[ch] = sat_XW(acc>>>FRAC); ch==N_CH-1 -> DONE else ch++ and -> NORM.
//  DONE (1 cyc): staged values copied to x_lin (all channels in same edge), srdyo=1, busy=0, -> IDLE.
//  x_lin holds previous batch until DONE; never partially updated.
//  Latency: srdyi sampled at edge 0 -> srdyo high in cycle N_CH*(ORDER+2)+1 (N_CH=16,ORDER=5: 113).
//  srdyi while busy=1: ignored, no queueing. srdyi during the srdyo cycle: state is DONE, ignored.
//  sat_N: clamp to [-2^(N-1), 2^(N-1)-1]; applied at NORM, every HORN step, WRITE.
// CONFIGURATION
//  NLC_ERR_EN defined: x_ref/err ports exist; x_ref sampled with srdyi; err[c] = |x_lin[c]-x_ref[c]| computed at WRITE, published at DONE.
//  NLC_ERR_EN undefined: ports absent, no error logic; all other timing identical.
// STRUCTURE
//  Package nlc_pkg: default W/FRAC/XW, state enum (IDLE,NORM,HORN,WRITE,DONE), sat functions.
//  Sub-module nlc_mac_fx: combinational signed a*b>>>FRAC + c with sat_W; shared by NORM (c=0) and HORN.
//  Top: FSM, ch/step counters, input shadow regs, staging and output registers.
// TESTING (N_CH=4, ORDER=5, FRAC=16 unless stated)
//  Identity: neg_mean=0, recip_stdev=0x10000, coeff1=0x10000, rest 0, x_adc=1000 on all ch -> x_lin=1000, srdyo at cycle 29.
//  Offset/square: neg_mean=-(5<<16), recip=0x10000, coeff2=0x10000, x_adc=8 -> x_lin=9; x_adc=2 -> 9.
//  Saturation: coeff0=+2^46 -> x_lin=0x0FFFFF; coeff0=-2^46 -> x_lin=0x100000; other ch unaffected.
//  Busy: second srdyi at cycle 10 with new x_adc -> ignored, one srdyo at 29, results from first batch.
//  Reset at cycle 15 -> no srdyo, x_lin=0, busy=0; next srdyi produces srdyo 29 cycles later.
//  NLC_ERR_EN: identity case with x_ref=990 -> err=10; x_ref=1010 -> err=10.

Source files
------------

// File: rtl/nlc_pkg.sv
// rtl/nlc_pkg.sv - shared widths, FSM state type and saturation helper for the NLC datapath
package nlc_pkg;

    localparam int XW_DEF   = 21;
    localparam int W_DEF    = 48;
    localparam int FRAC_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        HORN,
        WRITE,
        DONE
    } nlc_state_e;

    // Clamp v to the signed n-bit range; callers truncate the result to n bits (n <= 64).
    function automatic logic signed [127:0] sat_s(input logic signed [127:0] v, input int unsigned n);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (n - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nlc_horner_seq_if.sv
// rtl/nlc_horner_seq_if.sv - batch handshake and channel buses; x_ref/err exist only with NLC_ERR_EN
interface nlc_horner_seq_if #(
    parameter int N_CH  = 16,
    parameter int ORDER = 5,
    parameter int XW    = 21,
    parameter int W     = 48
);
    logic                        srdyi;
    logic                        srdyo;
    logic                        busy;
    logic [N_CH*XW-1:0]          x_adc;
    logic [N_CH*W-1:0]           neg_mean;
    logic [N_CH*W-1:0]           recip_stdev;
    logic [N_CH*(ORDER+1)*W-1:0] coeff;
    logic [N_CH*XW-1:0]          x_lin;
`ifdef NLC_ERR_EN
    logic [N_CH*XW-1:0]          x_ref;
    logic [N_CH*(XW+1)-1:0]      err;
`endif

    modport master (
`ifdef NLC_ERR_EN
        output x_ref,
        input  err,
`endif
        output srdyi, x_adc, neg_mean, recip_stdev, coeff,
        input  srdyo, busy, x_lin
    );

    modport slave (
`ifdef NLC_ERR_EN
        input  x_ref,
        output err,
`endif
        input  srdyi, x_adc, neg_mean, recip_stdev, coeff,
        output srdyo, busy, x_lin
    );
endinterface

// File: rtl/nlc_mac_fx.sv
// rtl/nlc_mac_fx.sv - combinational fixed-point y = sat_W(((a*b) >>> FRAC) + c)
module nlc_mac_fx
    import nlc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [W:0]   a_i,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] c_i,
    output logic signed [W-1:0] y_o
);
    logic signed [2*W:0]   prod;
    logic signed [2*W+1:0] sum;

    always_comb begin
        prod = a_i * b_i;
        sum  = (2*W+2)'(prod >>> FRAC) + (2*W+2)'(c_i);
        y_o  = W'(sat_s(128'(sum), W));
    end
endmodule

// File: rtl/nlc_horner_seq.sv
// rtl/nlc_horner_seq.sv - time-multiplexed per-channel normalise + Horner polynomial corrector (option: NLC_ERR_EN)
module nlc_horner_seq
    import nlc_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int ORDER = 5,
    parameter int XW    = XW_DEF,
    parameter int W     = W_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input logic              clk,
    input logic              reset,
    nlc_horner_seq_if.slave  bus
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KW  = (ORDER > 1) ? $clog2(ORDER) : 1;

    nlc_state_e                  state_q;
    logic [CHW-1:0]              ch_q;
    logic [KW-1:0]               step_q;
    logic                        srdyo_q;
    logic                        busy_q;
    logic [N_CH*XW-1:0]          x_adc_q;
    logic [N_CH*W-1:0]           neg_mean_q;
    logic [N_CH*W-1:0]           recip_q;
    logic [N_CH*(ORDER+1)*W-1:0] coeff_q;
    logic signed [W-1:0]         acc_q;
    logic signed [W-1:0]         xn_q;
    logic [N_CH*XW-1:0]          stage_q;
    logic [N_CH*XW-1:0]          x_lin_q;

    logic signed [XW-1:0] x_cur;
    logic signed [W:0]    t;
    logic signed [W:0]    mac_a;
    logic signed [W-1:0]  mac_b;
    logic signed [W-1:0]  mac_c;
    logic signed [W-1:0]  mac_y;
    logic signed [W-1:0]  coeff_k;
    logic signed [W-1:0]  coeff_top;
    logic signed [XW-1:0] y_lin;

    always_comb begin
        x_cur     = $signed(x_adc_q[int'(ch_q)*XW +: XW]);
        t         = ((W+1)'(x_cur) <<< FRAC) + (W+1)'($signed(neg_mean_q[int'(ch_q)*W +: W]));
        coeff_k   = $signed(coeff_q[(int'(ch_q)*(ORDER+1) + int'(step_q))*W +: W]);
        coeff_top = $signed(coeff_q[(int'(ch_q)*(ORDER+1) + ORDER)*W +: W]);
        y_lin     = XW'(sat_s(128'(acc_q >>> FRAC), XW));
        // One multiplier serves both phases: NORM scales t by 1/stdev, HORN folds in the next coefficient.
        if (state_q == NORM) begin
            mac_a = t;
            mac_b = $signed(recip_q[int'(ch_q)*W +: W]);
            mac_c = '0;
        end else begin
            mac_a = (W+1)'(acc_q);
            mac_b = xn_q;
            mac_c = coeff_k;
        end
    end

    nlc_mac_fx #(.W(W), .FRAC(FRAC)) u_mac (
        .a_i (mac_a),
        .b_i (mac_b),
        .c_i (mac_c),
        .y_o (mac_y)
    );

`ifdef NLC_ERR_EN
    logic [N_CH*XW-1:0]     x_ref_q;
    logic [N_CH*(XW+1)-1:0] err_stage_q;
    logic [N_CH*(XW+1)-1:0] err_q;
    logic signed [XW:0]     diff;
    logic [XW:0]            err_cur;

    always_comb begin
        diff    = (XW+1)'(y_lin) - (XW+1)'($signed(x_ref_q[int'(ch_q)*XW +: XW]));
        err_cur = (diff < 0) ? -diff : diff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_ref_q     <= '0;
            err_stage_q <= '0;
            err_q       <= '0;
        end else begin
            if (state_q == IDLE && bus.srdyi) begin
                x_ref_q <= bus.x_ref;
            end
            if (state_q == WRITE) begin
                err_stage_q[int'(ch_q)*(XW+1) +: XW+1] <= err_cur;
                if (ch_q == CHW'(N_CH - 1)) begin
                    for (int c = 0; c < N_CH - 1; c++) begin
                        err_q[c*(XW+1) +: XW+1] <= err_stage_q[c*(XW+1) +: XW+1];
                    end
                    err_q[(N_CH-1)*(XW+1) +: XW+1] <= err_cur;
                end
            end
        end
    end

    assign bus.err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            step_q     <= '0;
            srdyo_q    <= 1'b0;
            busy_q     <= 1'b0;
            x_adc_q    <= '0;
            neg_mean_q <= '0;
            recip_q    <= '0;
            coeff_q    <= '0;
            acc_q      <= '0;
            xn_q       <= '0;
            stage_q    <= '0;
            x_lin_q    <= '0;
        end else begin
            srdyo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.srdyi) begin
                        x_adc_q    <= bus.x_adc;
                        neg_mean_q <= bus.neg_mean;
                        recip_q    <= bus.recip_stdev;
                        coeff_q    <= bus.coeff;
                        ch_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    xn_q    <= mac_y;
                    acc_q   <= coeff_top;
                    step_q  <= KW'(ORDER - 1);
                    state_q <= HORN;
                end
                HORN: begin
                    acc_q <= mac_y;
                    if (step_q == '0) begin
                        state_q <= WRITE;
                    end else begin
                        step_q <= step_q - 1'b1;
                    end
                end
                WRITE: begin
                    stage_q[int'(ch_q)*XW +: XW] <= y_lin;
                    if (ch_q == CHW'(N_CH - 1)) begin
                        // Publish the whole batch at once; the last channel bypasses its staging slot.
                        for (int c = 0; c < N_CH - 1; c++) begin
                            x_lin_q[c*XW +: XW] <= stage_q[c*XW +: XW];
                        end
                        x_lin_q[(N_CH-1)*XW +: XW] <= y_lin;
                        srdyo_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= NORM;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.srdyo = srdyo_q;
    assign bus.busy  = busy_q;
    assign bus.x_lin = x_lin_q;
endmodule

// File: tb/tb_nlc_horner_seq.sv
// tb/tb_nlc_horner_seq.sv - directed-vector bench for nlc_horner_seq (N_CH=4, ORDER=5; NLC_ERR_EN cases when defined)
module tb_nlc_horner_seq;
    localparam int N_CH  = 4;
    localparam int ORDER = 5;
    localparam int XW    = 21;
    localparam int W     = 48;
    localparam int FRAC  = 16;
    localparam int LAT   = 29;
    localparam logic signed [W-1:0] ONE = 48'sd65536;
    localparam logic signed [W-1:0] P46 = 48'sd70368744177664;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    nlc_horner_seq_if #(.N_CH(N_CH), .ORDER(ORDER), .XW(XW), .W(W)) bus ();

    nlc_horner_seq #(.N_CH(N_CH), .ORDER(ORDER), .XW(XW), .W(W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int c, input int x, input logic signed [W-1:0] nm,
                          input logic signed [W-1:0] rs, input int k, input logic signed [W-1:0] cv);
        bus.x_adc[c*XW +: XW]     = XW'(x);
        bus.neg_mean[c*W +: W]    = nm;
        bus.recip_stdev[c*W +: W] = rs;
        for (int j = 0; j <= ORDER; j++) begin
            bus.coeff[(c*(ORDER+1)+j)*W +: W] = '0;
        end
        bus.coeff[(c*(ORDER+1)+k)*W +: W] = cv;
    endtask

    task automatic set_identity(input int x);
        for (int c = 0; c < N_CH; c++) begin
            set_ch(c, x, '0, ONE, 1, ONE);
        end
    endtask

    task automatic start_batch();
        @(negedge clk);
        bus.srdyi = 1'b1;
        @(posedge clk);
        #1;
        bus.srdyi = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = bus.busy;
            if (bus.srdyo) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_xlin(input string tag, input logic [XW-1:0] e0, input logic [XW-1:0] e1,
                              input logic [XW-1:0] e2, input logic [XW-1:0] e3);
        logic [XW-1:0] exp_v [N_CH];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("%s_xlin%0d", tag, c), 64'(bus.x_lin[c*XW +: XW]), 64'(exp_v[c]));
        end
    endtask

    task automatic run_and_check(input string tag, input logic [XW-1:0] e0, input logic [XW-1:0] e1,
                                 input logic [XW-1:0] e2, input logic [XW-1:0] e3);
        int   lat;
        logic busy1;
        start_batch();
        wait_done(lat, busy1);
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_run"}, 64'(busy1), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check_xlin(tag, e0, e1, e2, e3);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.srdyo), 64'd0);
    endtask

    initial begin
        int   lat;
        int   pulses;
        bus.srdyi       = 1'b0;
        bus.x_adc       = '0;
        bus.neg_mean    = '0;
        bus.recip_stdev = '0;
        bus.coeff       = '0;
`ifdef NLC_ERR_EN
        bus.x_ref       = '0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_srdyo", 64'(bus.srdyo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_xlin", 64'(bus.x_lin), 64'd0);

        // Identity polynomial: x_lin = x_adc.
        set_identity(1000);
        run_and_check("ident", 21'd1000, 21'd1000, 21'd1000, 21'd1000);

        // (x - 5)^2 with x = 8 and x = 2 both give 9.
        for (int c = 0; c < N_CH; c++) begin
            set_ch(c, (c < 2) ? 8 : 2, -(48'sd5 <<< 16), ONE, 2, ONE);
        end
        run_and_check("square", 21'd9, 21'd9, 21'd9, 21'd9);

        // Constant terms that overflow the output range clamp; other channels unaffected.
        set_identity(1000);
        set_ch(0, 1000, '0, ONE, 0, P46);
        set_ch(1, 1000, '0, ONE, 0, -P46);
        run_and_check("sat", 21'h0FFFFF, 21'h100000, 21'd1000, 21'd1000);

        // Second srdyi while busy must be ignored; x_lin holds the previous batch meanwhile.
        set_identity(1000);
        start_batch();
        pulses = 0;
        lat    = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 5) check("busy_hold", 64'(bus.x_lin[0 +: XW]), 64'(21'h0FFFFF));
            if (i == 10) begin
                set_identity(500);
                bus.srdyi = 1'b1;
            end
            if (i == 11) bus.srdyi = 1'b0;
            if (bus.srdyo) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_lat", 64'(lat), 64'(LAT));
        check_xlin("busy", 21'd1000, 21'd1000, 21'd1000, 21'd1000);

        // Reset mid-batch aborts it and clears outputs.
        set_identity(700);
        start_batch();
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 15) reset = 1'b1;
            if (i == 16) reset = 1'b0;
            if (bus.srdyo) pulses++;
        end
        check("abort_pulses", 64'(pulses), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check_xlin("abort", 21'd0, 21'd0, 21'd0, 21'd0);
        run_and_check("after_rst", 21'd700, 21'd700, 21'd700, 21'd700);

`ifdef NLC_ERR_EN
        set_identity(1000);
        for (int c = 0; c < N_CH; c++) begin
            bus.x_ref[c*XW +: XW] = (c < 2) ? 21'd990 : 21'd1010;
        end
        run_and_check("err", 21'd1000, 21'd1000, 21'd1000, 21'd1000);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("err%0d", c), 64'(bus.err[c*(XW+1) +: XW+1]), 64'd10);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end
endmodule
